// File: rtl/operand_sweep_gen_pkg.sv
// Shared widths and state encoding for the operand sweep generator.
package operand_sweep_gen_pkg;

    localparam int W     = 8;
    localparam int CNT_W = 2 * W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A range is usable only when neither axis is inverted.
    function automatic logic range_ok(input logic [W-1:0] a_lo, input logic [W-1:0] a_hi,
                                      input logic [W-1:0] b_lo, input logic [W-1:0] b_hi);
        return (a_lo <= a_hi) && (b_lo <= b_hi);
    endfunction

endpackage

// File: rtl/operand_sweep_gen_idx_counter.sv
// Nested a/b index counter: b is the inner axis, a the outer one.
// Row and sweep ends are detected by comparing against the bounds before
// incrementing, so a bound of all-ones never wraps back to zero.
import operand_sweep_gen_pkg::*;

module sweep_idx_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [CW-1:0] a_init,
    input  logic [CW-1:0] b_init,
    input  logic [CW-1:0] a_hi,
    input  logic [CW-1:0] b_lo,
    input  logic [CW-1:0] b_hi,
    output logic [CW-1:0] a,
    output logic [CW-1:0] b,
    output logic          last
);

    logic [CW-1:0] a_q, a_d;
    logic [CW-1:0] b_q, b_d;

    // Next index: load wins, otherwise advance b and roll into a at row end.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
            a_d = a_init;
            b_d = b_init;
        end else if (step) begin
            if (b_q == b_hi) begin
                b_d = b_lo;
                a_d = a_q + CW'(1);
            end else begin
                b_d = b_q + CW'(1);
            end
        end
    end

    // Index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign last = (a_q == a_hi) && (b_q == b_hi);

endmodule

// File: rtl/operand_sweep_gen.sv
// Operand sweep generator: walks a latched (a, b) rectangle and presents each
// pair on a valid/ready handshake, with done/cfg_err pulses and a pair count.
import operand_sweep_gen_pkg::*;

module operand_sweep_gen #(
    parameter int W     = operand_sweep_gen_pkg::W,
    parameter int CNT_W = 2 * W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     a_lo,
    input  logic [W-1:0]     a_hi,
    input  logic [W-1:0]     b_lo,
    input  logic [W-1:0]     b_hi,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] pair_cnt
);

    state_e           state_q, state_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // a_lo is only consumed at load time; the outer axis never rewinds, so
    // only the three bounds used mid-sweep are kept.
    logic [W-1:0]     a_hi_q, a_hi_d;
    logic [W-1:0]     b_lo_q, b_lo_d;
    logic [W-1:0]     b_hi_q, b_hi_d;

    logic             ld, step, last;
    logic             cfg_ok;

    assign cfg_ok = (a_lo <= a_hi) && (b_lo <= b_hi);

    // FSM, handshake accounting and bound latching.
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        a_hi_d  = a_hi_q;
        b_lo_d  = b_lo_q;
        b_hi_d  = b_hi_q;
        ld      = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        ld      = 1'b1;
                        a_hi_d  = a_hi;
                        b_lo_d  = b_lo;
                        b_hi_d  = b_hi;
                        cnt_d   = '0;
                        vld_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort beats a same-cycle handshake; that pair is dropped.
                if (abort) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else if (vld_q && out_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            a_hi_q  <= '0;
            b_lo_q  <= '0;
            b_hi_q  <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            a_hi_q  <= a_hi_d;
            b_lo_q  <= b_lo_d;
            b_hi_q  <= b_hi_d;
        end
    end

    sweep_idx_counter #(.CW(W)) u_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ld),
        .step   (step),
        .a_init (a_lo),
        .b_init (b_lo),
        .a_hi   (a_hi_q),
        .b_lo   (b_lo_q),
        .b_hi   (b_hi_q),
        .a      (a_out),
        .b      (b_out),
        .last   (last)
    );

    assign out_valid = vld_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign pair_cnt  = cnt_q;

endmodule

// File: tb/tb_operand_sweep_gen.sv
// Directed bench for operand_sweep_gen. Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_operand_sweep_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, out_ready;
    logic [7:0]  a_lo, a_hi, b_lo, b_hi;
    logic [7:0]  a_out, b_out;
    logic        out_valid, busy, done, cfg_err;
    logic [16:0] pair_cnt;

    int n_chk = 0;
    int n_fail = 0;

    operand_sweep_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_lo(a_lo), .a_hi(a_hi), .b_lo(b_lo), .b_hi(b_hi),
        .a_out(a_out), .b_out(b_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .cfg_err(cfg_err), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_range(input logic [7:0] al, input logic [7:0] ah,
                             input logic [7:0] bl, input logic [7:0] bh);
        a_lo = al; a_hi = ah; b_lo = bl; b_hi = bh;
    endtask

    // Issue start for one cycle; after this, the first pair should be visible.
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({a_out, b_out, out_valid, busy, done, cfg_err, pair_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset: a=%0d b=%0d v=%b busy=%b done=%b err=%b cnt=%0d, want all 0",
                     a_out, b_out, out_valid, busy, done, cfg_err, pair_cnt);
        end
    endtask

    // Range a 3..4, b 10..12 with out_ready held high.
    task automatic test_basic();
        logic [7:0] ea [6];
        logic [7:0] eb [6];
        ea = '{8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4};
        eb = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12};
        set_range(8'd3, 8'd4, 8'd10, 8'd12);
        out_ready = 1'b1;
        kick();
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (a_out !== ea[i] || b_out !== eb[i] || out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_pair%0d: got (%0d,%0d) v=%b busy=%b done=%b, want (%0d,%0d) v=1 busy=1 done=0",
                         i, a_out, b_out, out_valid, busy, done, ea[i], eb[i]);
            end
            tick();
        end
        n_chk++;
        if (out_valid !== 1'b0 || done !== 1'b1 || pair_cnt !== 17'd6 || busy !== 1'b0 ||
            a_out !== 8'd4 || b_out !== 8'd12) begin
            n_fail++;
            $display("FAIL basic_end: v=%b done=%b cnt=%0d busy=%b (%0d,%0d), want v=0 done=1 cnt=6 busy=0 (4,12)",
                     out_valid, done, pair_cnt, busy, a_out, b_out);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b err=%b, want 0 0", done, cfg_err);
        end
    endtask

    // Same range, 5-cycle stall on (3,11); bound inputs and start wiggled in RUN.
    task automatic test_backpressure();
        logic [7:0] ea [6];
        logic [7:0] eb [6];
        ea = '{8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4};
        eb = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12};
        set_range(8'd3, 8'd4, 8'd10, 8'd12);
        out_ready = 1'b1;
        kick();
        set_range(8'd0, 8'd3, 8'd0, 8'd11);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                out_ready = 1'b0;
                start = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    n_chk++;
                    if (a_out !== 8'd3 || b_out !== 8'd11 || out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall%0d: got (%0d,%0d) v=%b, want (3,11) v=1", s, a_out, b_out, out_valid);
                    end
                    tick();
                end
                start = 1'b0;
                out_ready = 1'b1;
            end
            n_chk++;
            if (a_out !== ea[i] || b_out !== eb[i] || out_valid !== 1'b1 || pair_cnt !== 17'(i)) begin
                n_fail++;
                $display("FAIL bp_pair%0d: got (%0d,%0d) v=%b cnt=%0d, want (%0d,%0d) v=1 cnt=%0d",
                         i, a_out, b_out, out_valid, pair_cnt, ea[i], eb[i], i);
            end
            tick();
        end
        n_chk++;
        if (out_valid !== 1'b0 || done !== 1'b1 || pair_cnt !== 17'd6) begin
            n_fail++;
            $display("FAIL bp_end: v=%b done=%b cnt=%0d, want v=0 done=1 cnt=6", out_valid, done, pair_cnt);
        end
        tick();
    endtask

    // a 254..255, b 255..255: no wrap to 0 may produce extra pairs.
    task automatic test_boundary();
        set_range(8'd254, 8'd255, 8'd255, 8'd255);
        out_ready = 1'b1;
        kick();
        n_chk++;
        if (a_out !== 8'd254 || b_out !== 8'd255 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_p0: got (%0d,%0d) v=%b, want (254,255) v=1", a_out, b_out, out_valid);
        end
        tick();
        n_chk++;
        if (a_out !== 8'd255 || b_out !== 8'd255 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_p1: got (%0d,%0d) v=%b, want (255,255) v=1", a_out, b_out, out_valid);
        end
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || done !== 1'b1 || pair_cnt !== 17'd2 || a_out !== 8'd255 || b_out !== 8'd255) begin
            n_fail++;
            $display("FAIL bnd_end: v=%b done=%b cnt=%0d (%0d,%0d), want v=0 done=1 cnt=2 (255,255)",
                     out_valid, done, pair_cnt, a_out, b_out);
        end
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bnd_idle: v=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    // Abort on the 3rd handshake cycle, then restart and finish.
    task automatic test_abort();
        set_range(8'd3, 8'd4, 8'd10, 8'd12);
        out_ready = 1'b1;
        kick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || pair_cnt !== 17'd2 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: v=%b cnt=%0d done=%b busy=%b, want v=0 cnt=2 done=0 busy=0",
                     out_valid, pair_cnt, done, busy);
        end
        tick();
        n_chk++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_nodone: done=%b v=%b, want 0 0", done, out_valid);
        end
        kick();
        n_chk++;
        if (a_out !== 8'd3 || b_out !== 8'd10 || out_valid !== 1'b1 || pair_cnt !== 17'd0) begin
            n_fail++;
            $display("FAIL abort_restart: got (%0d,%0d) v=%b cnt=%0d, want (3,10) v=1 cnt=0",
                     a_out, b_out, out_valid, pair_cnt);
        end
        for (int i = 0; i < 6; i++) tick();
        n_chk++;
        if (done !== 1'b1 || pair_cnt !== 17'd6) begin
            n_fail++;
            $display("FAIL abort_rerun: done=%b cnt=%0d, want 1 6", done, pair_cnt);
        end
        tick();
    endtask

    // Inverted a range: cfg_err pulse, nothing else moves.
    task automatic test_bad_cfg();
        set_range(8'd9, 8'd5, 8'd0, 8'd1);
        kick();
        n_chk++;
        if (cfg_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || pair_cnt !== 17'd6 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL badcfg: err=%b v=%b busy=%b cnt=%0d done=%b, want err=1 v=0 busy=0 cnt=6 done=0",
                     cfg_err, out_valid, busy, pair_cnt, done);
        end
        tick();
        n_chk++;
        if (cfg_err !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL badcfg_pulse: err=%b v=%b, want 0 0", cfg_err, out_valid);
        end
    endtask

    // Asynchronous reset mid-sweep, then a clean single-pair and full-range run.
    task automatic test_mid_reset();
        set_range(8'd3, 8'd4, 8'd10, 8'd12);
        out_ready = 1'b1;
        kick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({a_out, b_out, out_valid, busy, done, cfg_err, pair_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_rst: a=%0d b=%0d v=%b busy=%b done=%b err=%b cnt=%0d, want all 0",
                     a_out, b_out, out_valid, busy, done, cfg_err, pair_cnt);
        end
        #3 rst_n = 1'b1;
        tick();
        n_chk++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_nodone: done=%b v=%b, want 0 0", done, out_valid);
        end
        // Single-pair range: one handshake, then done.
        set_range(8'd7, 8'd7, 8'd9, 8'd9);
        kick();
        n_chk++;
        if (a_out !== 8'd7 || b_out !== 8'd9 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_p0: got (%0d,%0d) v=%b, want (7,9) v=1", a_out, b_out, out_valid);
        end
        tick();
        n_chk++;
        if (done !== 1'b1 || out_valid !== 1'b0 || pair_cnt !== 17'd1) begin
            n_fail++;
            $display("FAIL single_end: done=%b v=%b cnt=%0d, want 1 0 1", done, out_valid, pair_cnt);
        end
        tick();
        // Clean sweep of the original range after reset.
        set_range(8'd3, 8'd4, 8'd10, 8'd12);
        kick();
        n_chk++;
        if (a_out !== 8'd3 || b_out !== 8'd10 || pair_cnt !== 17'd0) begin
            n_fail++;
            $display("FAIL rst_restart: got (%0d,%0d) cnt=%0d, want (3,10) cnt=0", a_out, b_out, pair_cnt);
        end
        for (int i = 0; i < 6; i++) tick();
        n_chk++;
        if (done !== 1'b1 || pair_cnt !== 17'd6 || a_out !== 8'd4 || b_out !== 8'd12) begin
            n_fail++;
            $display("FAIL rst_rerun: done=%b cnt=%0d (%0d,%0d), want 1 6 (4,12)", done, pair_cnt, a_out, b_out);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        set_range(8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_backpressure();
        test_boundary();
        test_abort();
        test_bad_cfg();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
